// File: rtl/mem_crc_pkg.sv
// Shared types and the serial CRC step for the memory CRC checker.
package mem_crc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    CMP
  } state_t;

  // Widest CRC the step function handles; narrower CRCs are zero-extended.
  localparam int CRC_MAX_W = 32;
  localparam int ERR_COUNT_W = 8;

  // One MSB-first CRC step: fb = crc[msb] ^ bit, then shift and conditionally xor.
  function automatic logic [CRC_MAX_W-1:0] crc_step(
    input logic [CRC_MAX_W-1:0] crc,
    input logic                 bit_in,
    input logic [CRC_MAX_W-1:0] poly,
    input int                   width
  );
    logic                 fb;
    logic [CRC_MAX_W-1:0] mask;
    fb   = crc[5'(width - 1)] ^ bit_in;
    mask = (CRC_MAX_W'(1) << width) - CRC_MAX_W'(1);
    crc_step = ((crc << 1) ^ (fb ? poly : '0)) & mask;
  endfunction

endpackage

// File: rtl/crc_lfsr_serial.sv
// Serial MSB-first CRC LFSR: one bit per enabled cycle, synchronous clear.
module crc_lfsr_serial
  import mem_crc_pkg::*;
#(
  parameter int                         POLYNOMIAL_BITS = 1,
  parameter logic [POLYNOMIAL_BITS-1:0] POLYNOMIAL      = POLYNOMIAL_BITS'(1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       enable,
  input  logic                       bit_in,
  output logic [POLYNOMIAL_BITS-1:0] crc_out
);

  logic [CRC_MAX_W-1:0] crc_next;

  assign crc_next = crc_step(CRC_MAX_W'(crc_out), bit_in, CRC_MAX_W'(POLYNOMIAL),
                             POLYNOMIAL_BITS);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks evaluate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_out <= '0;
    end else if (clear) begin
      crc_out <= '0;
    end else if (enable) begin
      crc_out <= crc_next[POLYNOMIAL_BITS-1:0];
    end
  end

endmodule

// File: rtl/mem_crc_checker.sv
// Checks a stored data word against its stored CRC, recomputing the CRC
// serially, and keeps a sticky flag plus saturating count of mismatches.
module mem_crc_checker
  import mem_crc_pkg::*;
#(
  parameter int                         DATA_WIDTH      = 8,
  parameter int                         POLYNOMIAL_BITS = 1,
  parameter logic [POLYNOMIAL_BITS-1:0] POLYNOMIAL      = POLYNOMIAL_BITS'(1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       chk_start,
  input  logic [DATA_WIDTH-1:0]      mem_data_in,
  input  logic [POLYNOMIAL_BITS-1:0] crc_data_in,
  input  logic                       clr_err,
  output logic                       chk_busy,
  output logic                       chk_done,
  output logic                       chk_err,
  output logic                       err_sticky,
  output logic [ERR_COUNT_W-1:0]     err_count
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_t                       state;
  logic [DATA_WIDTH-1:0]        data_q;
  logic [POLYNOMIAL_BITS-1:0]   crc_q;
  logic [POLYNOMIAL_BITS-1:0]   crc_calc;
  logic [CNT_W-1:0]             bit_cnt;
  logic                         lfsr_clear;
  logic                         lfsr_enable;
  logic                         mismatch;

  assign lfsr_clear  = (state == IDLE) && chk_start;
  assign lfsr_enable = (state == CALC);
  assign mismatch    = (state == CMP) && (crc_calc != crc_q);
  assign chk_busy    = (state != IDLE);

  crc_lfsr_serial #(
    .POLYNOMIAL_BITS(POLYNOMIAL_BITS),
    .POLYNOMIAL     (POLYNOMIAL)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (lfsr_clear),
    .enable (lfsr_enable),
    .bit_in (data_q[DATA_WIDTH-1]),
    .crc_out(crc_calc)
  );

  // The data capture register doubles as a shift register feeding the LFSR
  // MSB first, so later changes on mem_data_in cannot reach the result.
  // NOTE: capture registers are ordinary flops, not a memory array, so they
  // take the async reset like everything else and reset leaves no stale word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_q   <= '0;
      crc_q    <= '0;
      bit_cnt  <= '0;
      chk_done <= 1'b0;
      chk_err  <= 1'b0;
    end else begin
      chk_done <= 1'b0;
      chk_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (chk_start) begin
            data_q  <= mem_data_in;
            crc_q   <= crc_data_in;
            bit_cnt <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          data_q  <= data_q << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state <= CMP;
          end
        end
        CMP: begin
          chk_done <= 1'b1;
          chk_err  <= mismatch;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A clear coinciding with a mismatch lands the count at 1, not 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (clr_err) begin
      err_sticky <= mismatch;
      err_count  <= mismatch ? ERR_COUNT_W'(1) : '0;
    end else if (mismatch) begin
      err_sticky <= 1'b1;
      if (err_count != {ERR_COUNT_W{1'b1}}) begin
        err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_crc_checker.sv
// Directed bench: default 1-bit parity checker plus a CRC-8 (poly 0x07) instance.
module tb_mem_crc_checker;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       a_start, a_clr, a_crc;
  logic [7:0] a_mem;
  logic       a_busy, a_done, a_err, a_sticky;
  logic [7:0] a_count;

  logic       b_start, b_clr;
  logic [7:0] b_mem, b_crc;
  logic       b_busy, b_done, b_err, b_sticky;
  logic [7:0] b_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_crc_checker dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chk_start  (a_start),
    .mem_data_in(a_mem),
    .crc_data_in(a_crc),
    .clr_err    (a_clr),
    .chk_busy   (a_busy),
    .chk_done   (a_done),
    .chk_err    (a_err),
    .err_sticky (a_sticky),
    .err_count  (a_count)
  );

  mem_crc_checker #(
    .DATA_WIDTH     (8),
    .POLYNOMIAL_BITS(8),
    .POLYNOMIAL     (8'h07)
  ) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .chk_start  (b_start),
    .mem_data_in(b_mem),
    .crc_data_in(b_crc),
    .clr_err    (b_clr),
    .chk_busy   (b_busy),
    .chk_done   (b_done),
    .chk_err    (b_err),
    .err_sticky (b_sticky),
    .err_count  (b_count)
  );

  // Runs one check on the default instance. cyc counts negedges after the one
  // that raised chk_start; done is expected at cyc 10 (9 cycles after E0).
  // clr_at pulses clr_err at that negedge; disturb_at scrambles inputs and
  // re-pulses chk_start while busy.
  task automatic run_a(input logic [7:0] d, input logic c, output logic err_o,
                       output int cyc, input int clr_at = -1, input int disturb_at = -1);
    logic got;
    got   = 1'b0;
    err_o = 1'b0;
    cyc   = 0;
    @(negedge clk);
    a_mem   = d;
    a_crc   = c;
    a_start = 1'b1;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      a_start = (cyc == disturb_at);
      a_clr   = (cyc == clr_at);
      if (cyc == disturb_at) begin
        a_mem = d ^ 8'h01;
        a_crc = ~c;
      end
      if (a_done) begin
        got   = 1'b1;
        err_o = a_err;
      end else begin
        n_checks++;
        if (a_err !== 1'b0) begin
          n_fail++;
          $display("FAIL chk_err_without_done: cyc %0d got %b want 0", cyc, a_err);
        end
      end
    end
    a_start = 1'b0;
    a_clr   = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_timeout: no chk_done within %0d cycles", cyc);
    end
  endtask

  task automatic run_b(input logic [7:0] d, input logic [7:0] c, output logic err_o,
                       output int cyc);
    logic got;
    got   = 1'b0;
    err_o = 1'b0;
    cyc   = 0;
    @(negedge clk);
    b_mem   = d;
    b_crc   = c;
    b_start = 1'b1;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      b_start = 1'b0;
      if (b_done) begin
        got   = 1'b1;
        err_o = b_err;
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_timeout_crc8: no chk_done within %0d cycles", cyc);
    end
  endtask

  task automatic expect_bit(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic expect_int(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    a_start = 1'b0; a_clr = 1'b0; a_mem = '0; a_crc = 1'b0;
    b_start = 1'b0; b_clr = 1'b0; b_mem = '0; b_crc = '0;
    #1;
    expect_bit("reset_busy",   a_busy,   1'b0);
    expect_bit("reset_done",   a_done,   1'b0);
    expect_bit("reset_err",    a_err,    1'b0);
    expect_bit("reset_sticky", a_sticky, 1'b0);
    expect_int("reset_count",  a_count,  0);
    expect_bit("reset_busy8",  b_busy,   1'b0);
    expect_int("reset_count8", b_count,  0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_match();
    logic e; int cyc;
    run_a(8'hA5, 1'b0, e, cyc);
    expect_int("match_latency", cyc - 1, 9);
    expect_bit("match_err",     e,        1'b0);
    expect_int("match_count",   a_count,  0);
    expect_bit("match_sticky",  a_sticky, 1'b0);
    expect_bit("match_idle",    a_busy,   1'b0);
  endtask

  task automatic test_mismatch();
    logic e; int cyc;
    run_a(8'hA5, 1'b1, e, cyc);
    expect_bit("mismatch_err",    e,        1'b1);
    expect_bit("mismatch_sticky", a_sticky, 1'b1);
    expect_int("mismatch_count",  a_count,  1);
  endtask

  // Inputs flipped mid-check would mismatch if they leaked into the result.
  task automatic test_capture_ignore();
    logic e; int cyc;
    run_a(8'hA5, 1'b0, e, cyc, -1, 3);
    expect_int("ignore_latency", cyc, 10);
    expect_bit("ignore_err",     e,       1'b0);
    expect_int("ignore_count",   a_count, 1);
    @(negedge clk);
    expect_bit("ignore_no_restart", a_busy, 1'b0);
  endtask

  task automatic test_crc8();
    logic e; int cyc;
    run_b(8'h01, 8'h07, e, cyc);
    expect_bit("crc8_01_07", e, 1'b0);
    run_b(8'h80, 8'h89, e, cyc);
    expect_bit("crc8_80_89", e, 1'b0);
    expect_int("crc8_latency", cyc - 1, 9);
    run_b(8'h80, 8'h88, e, cyc);
    expect_bit("crc8_80_88", e, 1'b1);
    expect_int("crc8_count", b_count, 1);
  endtask

  task automatic test_back_to_back();
    int cyc, last, ndone;
    @(negedge clk); a_clr = 1'b1;
    @(negedge clk); a_clr = 1'b0;
    expect_int("b2b_precleared", a_count, 0);
    a_mem   = 8'hA5;
    a_crc   = 1'b1;
    a_start = 1'b1;
    cyc = 0; last = 0; ndone = 0;
    while (ndone < 300 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (a_done) begin
        ndone++;
        expect_int("b2b_period", cyc - last, 10);
        last = cyc;
        if (ndone == 300) a_start = 1'b0;
      end
    end
    a_start = 1'b0;
    expect_int("b2b_done_count", ndone, 300);
    expect_int("b2b_saturated",  a_count, 255);
    expect_bit("b2b_sticky",     a_sticky, 1'b1);
    repeat (2) @(negedge clk);
    expect_bit("b2b_stopped", a_busy, 1'b0);
  endtask

  task automatic test_clr();
    logic e; int cyc;
    run_a(8'hA5, 1'b1, e, cyc, 9);
    expect_bit("clr_same_err",    e,        1'b1);
    expect_int("clr_same_count",  a_count,  1);
    expect_bit("clr_same_sticky", a_sticky, 1'b1);
    @(negedge clk); a_clr = 1'b1;
    @(negedge clk); a_clr = 1'b0;
    expect_int("clr_alone_count",  a_count,  0);
    expect_bit("clr_alone_sticky", a_sticky, 1'b0);
    run_a(8'hA5, 1'b1, e, cyc);
    run_a(8'hA5, 1'b1, e, cyc, 4);
    expect_int("clr_mid_latency", cyc, 10);
    expect_bit("clr_mid_err",     e,       1'b1);
    expect_int("clr_mid_count",   a_count, 1);
  endtask

  task automatic test_reset_mid();
    logic e, saw_done; int cyc;
    saw_done = 1'b0;
    @(negedge clk);
    a_mem = 8'hA5; a_crc = 1'b1; a_start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      a_start = 1'b0;
    end
    expect_bit("rstmid_busy_before", a_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    expect_bit("rstmid_busy", a_busy, 1'b0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (a_done) saw_done = 1'b1;
    end
    expect_bit("rstmid_no_done", saw_done, 1'b0);
    expect_int("rstmid_count",   a_count,  0);
    expect_bit("rstmid_sticky",  a_sticky, 1'b0);
    run_a(8'hA5, 1'b1, e, cyc);
    expect_int("rstmid_after_latency", cyc, 10);
    expect_bit("rstmid_after_err",     e,       1'b1);
    expect_int("rstmid_after_count",   a_count, 1);
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_capture_ignore();
    test_crc8();
    test_back_to_back();
    test_clr();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_crc_checker.md
MEM_CRC_CHECKER -- requirements
Module: mem_crc_checker

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of the protected data word.
REQ-002 The block SHALL have parameter POLYNOMIAL_BITS, default 1, giving the CRC width.
REQ-003 The block SHALL have parameter POLYNOMIAL, default 1 (POLYNOMIAL_BITS wide), holding the generator polynomial without its implicit top term.
REQ-004 The block SHALL use clock clk, an input of width 1, with all state updating on its rising edge.
REQ-005 The block SHALL use reset rst_n, an input of width 1, asynchronous and active-low.
REQ-006 The block SHALL have chk_start, input, width 1: request to check the current word.
REQ-007 The block SHALL have mem_data_in, input, width DATA_WIDTH: stored data word, driven from the memory stage read port.
REQ-008 The block SHALL have crc_data_in, input, width POLYNOMIAL_BITS: stored CRC, driven from the memory stage read port.
REQ-009 The block SHALL have clr_err, input, width 1: clears err_sticky and err_count.
REQ-010 The block SHALL have chk_busy, output, width 1: a check is in progress.
REQ-011 The block SHALL have chk_done, output, width 1: a one-cycle result-valid pulse.
REQ-012 The block SHALL have chk_err, output, width 1: mismatch result, valid only while chk_done=1.
REQ-013 The block SHALL have err_sticky, output, width 1: latched indication that any mismatch has occurred.
REQ-014 The block SHALL have err_count, output, width 8: saturating count of mismatches.

Function
REQ-015 The CRC SHALL be computed serially, MSB first, with init all-zeros, no reflection and no final XOR.
REQ-016 Each step SHALL compute fb = crc[MSB] ^ bit and crc_next = (crc << 1) ^ (fb ? POLYNOMIAL : 0).
REQ-017 The FSM SHALL have exactly three states: IDLE, CALC and CMP.
REQ-018 In IDLE, chk_start=1 at edge E0 SHALL capture mem_data_in and crc_data_in into internal registers, clear the running CRC and bit counter, and move to CALC.
REQ-019 In CALC, one data bit SHALL be processed per cycle at edges E1..E_DATA_WIDTH, after which the FSM SHALL move to CMP.
REQ-020 In CMP, edge E_DATA_WIDTH+1 SHALL register chk_done=1 and chk_err=(computed CRC != captured CRC), then return to IDLE.
REQ-021 Latency from the edge sampling chk_start to chk_done being high SHALL be DATA_WIDTH+1 cycles.
REQ-022 chk_busy SHALL be 1 exactly when state != IDLE.
REQ-023 chk_start SHALL be ignored while busy, and mem_data_in/crc_data_in changes after capture SHALL have no effect on the result.
REQ-024 chk_start asserted in the cycle where chk_done=1 SHALL be accepted, giving back-to-back checks every DATA_WIDTH+2 cycles.
REQ-025 chk_err SHALL be 0 whenever chk_done=0.
REQ-026 On a mismatch, err_sticky SHALL be set to 1 and err_count SHALL increment, saturating at 255.
REQ-027 When clr_err=1 and a mismatch result occur in the same cycle, the clear SHALL be applied first, giving err_count=1 and err_sticky=1.
REQ-028 clr_err SHALL NOT affect a check in progress.

Reset
REQ-029 When rst_n=0, the block SHALL set state=IDLE and chk_busy=0, chk_done=0, chk_err=0, err_sticky=0, err_count=0, with the capture registers and CRC cleared.
REQ-030 Reset asserted mid-check SHALL abort the check with no chk_done pulse and no error counted.

Structure
REQ-031 The state enum and a function computing one serial CRC step SHALL be placed in the shared package mem_crc_pkg.
REQ-032 The per-bit LFSR SHALL be implemented in sub-module crc_lfsr_serial, with ports clk, rst_n, clear, enable, bit_in and crc_out.
REQ-033 The bit counter SHALL be $clog2(DATA_WIDTH)+1 bits wide.

Verification
REQ-034 With defaults, mem_data_in=8'hA5, crc_data_in=0 and chk_start pulsed -> chk_done 9 cycles later, chk_err=0, err_count=0.
REQ-035 With defaults, 8'hA5 and crc_data_in=1 -> chk_err=1, err_sticky=1, err_count=1.
REQ-036 With POLYNOMIAL_BITS=8 and POLYNOMIAL=8'h07, data 8'h01 with crc 8'h07 and data 8'h80 with crc 8'h89 -> chk_err=0 for both; data 8'h80 with crc 8'h88 -> chk_err=1.
REQ-037 Applying 300 consecutive mismatching checks back-to-back (start asserted on the done cycle) -> err_count=255 and a period of 10 cycles per check.
REQ-038 Asserting clr_err on the same cycle as a mismatch done -> err_count=1; then asserting clr_err alone -> err_count=0 and err_sticky=0.
REQ-039 Dropping rst_n at cycle 4 of a check -> chk_busy=0 immediately with no chk_done pulse; a subsequent check completes correctly.
